// File: rtl/iter_shift_right.sv
// Multi-cycle right shifter for SRL/SRA/SRLV/SRAV in the EX stage.
// Moves the operand at most STEP bits per clock under a start/busy/done handshake.
module iter_shift_right #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    // STEP may equal WIDTH, which does not fit in SHAMT_W bits.
    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic               fill;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        if ({1'b0, cnt} < STEP_W) begin
            k = cnt;
        end else begin
            k = STEP_W[SHAMT_W-1:0];
        end
    end

    // Inverting around a logical shift yields a one-filled shift.
    always_comb begin
        if (fill) begin
            shifted = ~((~acc) >> k);
        end else begin
            shifted = acc >> k;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_SHIFT);
            done  <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            cnt  <= '0;
            fill <= 1'b0;
            dout <= '0;
        end else begin
            if (load) begin
                acc  <= din;
                cnt  <= shamt;
                fill <= arith & din[WIDTH-1];
            end else if (state == S_SHIFT) begin
                if (cnt != '0) begin
                    acc <= shifted;
                    cnt <= cnt - k;
                end else begin
                    dout <= acc;
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_shift_right.sv
// Bench for iter_shift_right: STEP=1 and STEP=8 instances,
// vector tables plus scoreboard-checked multi-cycle sequences.
module tb_iter_shift_right;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1;
    logic        start8;
    logic        arith;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic        busy1;
    logic        done1;
    logic [31:0] dout1;
    logic        busy8;
    logic        done8;
    logic [31:0] dout8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dout;
        int          lat;
    } exp_t;

    typedef struct {
        logic        arith;
        logic [4:0]  shamt;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    exp_t q1[$];
    exp_t q8[$];
    vec_t v1[7];
    vec_t v8[5];

    iter_shift_right #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .arith(arith),
        .shamt(shamt), .din(din), .busy(busy1), .done(done1),
        .dout(dout1)
    );

    iter_shift_right #(.WIDTH(32), .SHAMT_W(5), .STEP(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .arith(arith),
        .shamt(shamt), .din(din), .busy(busy8), .done(done8),
        .dout(dout8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic a, input logic [4:0] s,
                                          input logic [31:0] d);
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    // Drive one request; the following rising edge samples it.
    task automatic issue(input bit s8, input logic a, input logic [4:0] s,
                         input logic [31:0] d, input logic [31:0] e);
        exp_t x;
        arith = a;
        shamt = s;
        din   = d;
        x.dout = e;
        if (s8) begin
            start8 = 1'b1;
            x.lat  = (int'(s) + 7) / 8 + 1;
            q8.push_back(x);
        end else begin
            start1 = 1'b1;
            x.lat  = int'(s) + 1;
            q1.push_back(x);
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start8 = 1'b0;
    endtask

    // Returns in the cycle where done is seen, without advancing past it.
    task automatic wait_done(input bit s8, input int poke);
        exp_t e;
        int   n   = 0;
        int   bc  = 0;
        bit   got = 1'b0;
        while (n <= 40) begin
            if (n == poke) begin
                din   = $urandom;
                shamt = 5'd3;
                arith = 1'b1;
                if (s8) start8 = 1'b1;
                else start1 = 1'b1;
            end else begin
                start1 = 1'b0;
                start8 = 1'b0;
            end
            if (s8 ? done8 : done1) begin
                got = 1'b1;
                break;
            end
            if (s8 ? busy8 : busy1) bc++;
            @(posedge clk);
            #1;
            n++;
        end
        start1 = 1'b0;
        start8 = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=no_done required=done");
            if (s8 && q8.size() > 0) void'(q8.pop_front());
            if (!s8 && q1.size() > 0) void'(q1.pop_front());
            return;
        end
        if ((s8 ? q8.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done required=none");
            return;
        end
        e = s8 ? q8.pop_front() : q1.pop_front();
        chk("dout", s8 ? dout8 : dout1, e.dout);
        chk("latency", 32'(n), 32'(e.lat));
        chk("busy_cycles", 32'(bc), 32'(e.lat));
    endtask

    task automatic idle_after(input bit s8);
        @(posedge clk);
        #1;
        chk("done_width", {31'd0, s8 ? done8 : done1}, 32'd0);
        chk("idle_busy", {31'd0, s8 ? busy8 : busy1}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        int          nd;

        v1[0] = '{1'b0, 5'd4,  32'h80000010, 32'h08000001};
        v1[1] = '{1'b1, 5'd4,  32'h80000010, 32'hF8000001};
        v1[2] = '{1'b1, 5'd31, 32'h7FFFFFFF, 32'h00000000};
        v1[3] = '{1'b1, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
        v1[4] = '{1'b0, 5'd31, 32'h80000000, 32'h00000001};
        v1[5] = '{1'b1, 5'd16, 32'h80001234, 32'hFFFF8000};
        v1[6] = '{1'b0, 5'd1,  32'hFFFFFFFF, 32'h7FFFFFFF};
        v8[0] = '{1'b1, 5'd31, 32'h80000000, 32'hFFFFFFFF};
        v8[1] = '{1'b0, 5'd8,  32'h12345678, 32'h00123456};
        v8[2] = '{1'b1, 5'd7,  32'hF0000000, 32'hFFE00000};
        v8[3] = '{1'b0, 5'd9,  32'hFFFFFFFF, 32'h007FFFFF};
        v8[4] = '{1'b1, 5'd0,  32'h87654321, 32'h87654321};

        reset  = 1'b1;
        start1 = 1'b0;
        start8 = 1'b0;
        arith  = 1'b0;
        shamt  = '0;
        din    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_done1", {31'd0, done1}, 32'd0);
        chk("rst_dout1", dout1, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_dout8", dout8, 32'd0);

        for (int i = 0; i < 7; i++) begin
            issue(1'b0, v1[i].arith, v1[i].shamt, v1[i].din, v1[i].exp);
            wait_done(1'b0, -1);
            idle_after(1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, v8[i].arith, v8[i].shamt, v8[i].din, v8[i].exp);
            wait_done(1'b1, -1);
            idle_after(1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            issue(1'b0, a, s, d, model(a, s, d));
            wait_done(1'b0, -1);
            d = $urandom;
            issue(1'b1, a, s, d, model(a, s, d));
            wait_done(1'b1, -1);
        end
        idle_after(1'b1);

        // Start during SHIFT is ignored; start in DONE is accepted back-to-back.
        issue(1'b0, 1'b1, 5'd10, 32'hA5A50000, 32'hFFE96940);
        wait_done(1'b0, 2);
        issue(1'b0, 1'b0, 5'd5, 32'h0000F0F0, 32'h00000787);
        wait_done(1'b0, -1);
        idle_after(1'b0);
        issue(1'b1, 1'b0, 5'd20, 32'hFFF00000, 32'h00000FFF);
        wait_done(1'b1, 1);
        issue(1'b1, 1'b1, 5'd17, 32'h90000000, 32'hFFFFC800);
        wait_done(1'b1, -1);
        idle_after(1'b1);

        // Reset in the middle of a long operation aborts it silently.
        issue(1'b0, 1'b0, 5'd20, 32'hFFFFFFFF, 32'h00000FFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q1.delete();
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_dout", dout1, 32'd0);
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done1) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        issue(1'b0, 1'b1, 5'd3, 32'h80000008, 32'hF0000001);
        wait_done(1'b0, -1);
        idle_after(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
